key_repeat: RTL

KEY_REPEAT -- requirements
Module: key_repeat

---
 rtl/key_repeat.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/key_repeat.sv
// key_repeat: turns a raw per-frame USB keycode into one-cycle key events.
// Arrows and backspace auto-repeat after HOLD_DELAY frames, then every
// REPEAT_PERIOD frames. Letters fire once per press. Everything else is ignored.
//
// Ports
//   frame_clk   : sole clock; all state updates on its rising edge
//   Reset       : synchronous, active-high reset
//   keycode_in  : raw keycode, sampled every edge (8'h00 = no key)
//   keycode_out : event keycode, nonzero for one cycle per event, else 8'h00
//   key_valid   : high exactly when keycode_out is nonzero
//   repeating   : high while the FSM is in REPEAT
module key_repeat #(
    parameter int unsigned HOLD_DELAY    = 30,
    parameter int unsigned REPEAT_PERIOD = 6
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode_in,
    output logic [7:0] keycode_out,
    output logic       key_valid,
    output logic       repeating
);

    localparam int unsigned KEY_W = 8;
    localparam int unsigned CNT_W = 8;

    localparam logic [CNT_W-1:0] HOLD_CNT   = CNT_W'(HOLD_DELAY);
    localparam logic [CNT_W-1:0] REPEAT_CNT = CNT_W'(REPEAT_PERIOD);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HELD,
        ST_REPEAT,
        ST_LATCHED
    } state_t;

    typedef enum logic [1:0] {
        KC_IGNORE,
        KC_REPEAT,
        KC_SINGLE
    } key_class_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [KEY_W-1:0] r_key;
    logic [KEY_W-1:0] r_keycode_out;
    logic             r_key_valid;
    logic             r_repeating;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [KEY_W-1:0] w_key_nxt;
    logic             w_pulse;
    key_class_t       w_class;

    // Key classification of the current sample.
    always_comb begin
        w_class = KC_IGNORE;
        if ((keycode_in >= 8'h4F && keycode_in <= 8'h52) || keycode_in == 8'h2A) begin
            w_class = KC_REPEAT;
        end else if (keycode_in >= 8'h04 && keycode_in <= 8'h1D) begin
            w_class = KC_SINGLE;
        end
    end

    // State, counter and stored key registers.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_key         <= '0;
            r_keycode_out <= '0;
            r_key_valid   <= 1'b0;
            r_repeating   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_key         <= w_key_nxt;
            r_keycode_out <= w_pulse ? keycode_in : '0;
            r_key_valid   <= w_pulse;
            r_repeating   <= (w_state_nxt == ST_REPEAT);
        end
    end

    // Next-state and pulse decision.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_key_nxt   = r_key;
        w_pulse     = 1'b0;

        if (w_class == KC_IGNORE) begin
            // Release or unsupported key always drops back to IDLE silently.
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_key_nxt   = '0;
        end else if (r_state == ST_IDLE || keycode_in != r_key) begin
            // New press, including a direct switch to a different key.
            w_pulse   = 1'b1;
            w_key_nxt = keycode_in;
            if (w_class == KC_REPEAT) begin
                w_state_nxt = ST_HELD;
                w_cnt_nxt   = CNT_W'(1);
            end else begin
                w_state_nxt = ST_LATCHED;
                w_cnt_nxt   = '0;
            end
        end else begin
            // Same key still held.
            case (r_state)
                ST_HELD: begin
                    if (r_cnt == HOLD_CNT) begin
                        w_pulse     = 1'b1;
                        w_cnt_nxt   = CNT_W'(1);
                        w_state_nxt = ST_REPEAT;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (r_cnt == REPEAT_CNT) begin
                        w_pulse   = 1'b1;
                        w_cnt_nxt = CNT_W'(1);
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                ST_LATCHED: begin
                    w_state_nxt = ST_LATCHED;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_key_nxt   = '0;
                end
            endcase
        end
    end

    assign keycode_out = r_keycode_out;
    assign key_valid   = r_key_valid;
    assign repeating   = r_repeating;

endmodule
